fork_join_sched: RTL

- Hardware scheduler for timed jobs that mirrors fork/join semantics.
- Accepts a "fork" of up to N_JOBS jobs, each with its own cycle duration. All jobs run concurrently on per-job down-counters.
- Emits per-job start and done pulses, plus one parent-release pulse timed by the selected join mode (join all / join_any / join_none).
- Sits between the test-sequence controller and the timed-job resources. It sequences them and tells the parent when it may continue.

---
 rtl/fork_join_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/fork_join_sched.sv
// fork_join_sched: timed-job fork/join scheduler with join-all/any/none release (optional FJ_KILL_EN adds fork_kill)
module fork_join_sched #(
  parameter int N_JOBS = 3,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef FJ_KILL_EN
  input  logic                    fork_kill,
`endif
  input  logic                    fork_valid,
  output logic                    fork_ready,
  input  logic [N_JOBS-1:0]       fork_mask,
  input  logic [1:0]              fork_mode,
  input  logic [N_JOBS*CNT_W-1:0] fork_dur,
  output logic [N_JOBS-1:0]       job_start,
  output logic [N_JOBS-1:0]       job_active,
  output logic [N_JOBS-1:0]       job_done,
  output logic                    join_release,
  output logic                    join_pending
);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [N_JOBS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_JOBS-1:0] mask_q, mask_d, start_q, start_d, active_q, active_d, done_q, done_d;
  logic [1:0] mode_q, mode_d;
  logic launch_q, launch_d, rel_q, rel_d, pend_q, pend_d;
  logic kill, accept, rel_open, mode_all;
`ifdef FJ_KILL_EN
  assign kill = fork_kill;
`else
  assign kill = 1'b0;
`endif
  assign fork_ready   = state_q == IDLE;
  assign accept       = fork_valid && fork_ready && !kill;
  assign rel_open     = state_q == WAIT && !rel_q;
  assign mode_all     = mode_q != 2'b01 && mode_q != 2'b10;
  assign job_start    = start_q;
  assign job_active   = active_q;
  assign job_done     = done_q;
  assign join_release = rel_q;
  assign join_pending = pend_q;
  // Counter countdown, fork launch, release decision and FSM next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    mode_d   = mode_q;
    launch_d = 1'b0;
    done_d   = '0;
    active_d = '0;
    start_d  = launch_q ? mask_q : '0;
    for (int i = 0; i < N_JOBS; i++) begin
      if (cnt_q[i] != '0) begin
        cnt_d[i]    = cnt_q[i] - 1'b1;
        done_d[i]   = cnt_q[i] == CNT_W'(1);
        active_d[i] = cnt_q[i] != CNT_W'(1);
      end
    end
    if (accept) begin
      for (int i = 0; i < N_JOBS; i++)
        cnt_d[i] = !fork_mask[i] ? '0 : (fork_dur[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1) : fork_dur[i*CNT_W +: CNT_W];
      mask_d   = fork_mask;
      mode_d   = fork_mode;
      launch_d = 1'b1;
      state_d  = WAIT;
    end
    rel_d = rel_open && ((launch_q && (mode_q == 2'b10 || mask_q == '0)) ||
                         (mode_q == 2'b01 && |done_d) ||
                         (mode_all && |done_d && cnt_d == '0));
    if (state_q == WAIT && rel_q) state_d = (cnt_q != '0) ? DRAIN : IDLE;
    if (state_q == DRAIN && cnt_q == '0) state_d = IDLE;
    if (kill) begin
      cnt_d    = '0;
      done_d   = '0;
      active_d = '0;
      start_d  = '0;
      launch_d = 1'b0;
      rel_d    = rel_open;
    end
    pend_d = (pend_q | launch_q) & ~rel_d & ~kill;
  end
  // State and pulse registers with synchronous reset that silently aborts all jobs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      launch_q <= 1'b0;
      start_q  <= '0;
      active_q <= '0;
      done_q   <= '0;
      rel_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      launch_q <= launch_d;
      start_q  <= start_d;
      active_q <= active_d;
      done_q   <= done_d;
      rel_q    <= rel_d;
      pend_q   <= pend_d;
    end
  end
endmodule
